// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, write-op encoding,
// mstatus field positions, trap cause codes and the read-modify-write helper.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   typedef enum logic [1:0] {
      WR_NOP = 2'b00,
      WR_RW  = 2'b01,
      WR_RS  = 2'b10,
      WR_RC  = 2'b11
   } wr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;
   localparam logic [31:0] CAUSE_BREAKPOINT   = 32'd3;
   localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;

   function automatic logic csr_implemented(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
         CSR_MVENDORID, CSR_MARCHID: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] csr_rmw(input wr_op_e op, input logic [31:0] old_v,
                                           input logic [31:0] src);
      case (op)
         WR_RW:   return src;
         WR_RS:   return old_v | src;
         WR_RC:   return old_v & ~src;
         default: return old_v;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to one half wins over the increment; the other half holds that cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] value_o
);

   logic [63:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + {63'd0, inc_i};
      if (wr_lo_i) begin
         cnt_d = {cnt_q[63:32], wdata_i};
      end else if (wr_hi_i) begin
         cnt_d = {wdata_i, cnt_q[31:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file: combinational read with optional write bypass, registered
// CSRRW/RS/RC writes, trap entry / MRET sequencing and mcycle/minstret counters.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int          XLEN          = 32,
   parameter bit          HAS_COUNTERS  = 1'b1,
   parameter bit          RD_BYPASS     = 1'b1,
   parameter logic [31:0] MSTATUS_RST   = 32'h0000_1800,
   parameter logic [31:0] MTVEC_RST     = 32'h0,
   parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_illegal,
   input  logic            wr_en,
   input  logic [1:0]      wr_op,
   input  logic [11:0]     wr_addr,
   input  logic [XLEN-1:0] wr_src,
   output logic            wr_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic            mret_valid,
   input  logic            retire,
   output logic [XLEN-1:0] trap_vec,
   output logic [XLEN-1:0] epc,
   output logic            mie
);

   if (XLEN != 32) begin : g_xlen_check
      $error("csr_trap_unit supports XLEN=32 only");
   end

   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d, mscratch_q, mscratch_d;
   logic [63:0]     mcycle, minstret;

   logic            wr_legal, wr_fire, wr_blocked, wr_commit;
   logic [XLEN-1:0] wr_raw, wr_val;

   // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
   function automatic logic [XLEN-1:0] mstatus_word(input logic ie, input logic pie);
      logic [XLEN-1:0] w;
      w = '0;
      w[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      w[MSTATUS_MIE]  = ie;
      w[MSTATUS_MPIE] = pie;
      return w;
   endfunction

   function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS:   return mstatus_word(mie_q, mpie_q);
         CSR_MTVEC:     return mtvec_q;
         CSR_MSCRATCH:  return mscratch_q;
         CSR_MEPC:      return mepc_q;
         CSR_MCAUSE:    return mcause_q;
         CSR_MCYCLE:    return mcycle[31:0];
         CSR_MCYCLEH:   return mcycle[63:32];
         CSR_MINSTRET:  return minstret[31:0];
         CSR_MINSTRETH: return minstret[63:32];
         CSR_MVENDORID: return MVENDORID_VAL;
         default:       return '0;
      endcase
   endfunction

   always_comb begin
      wr_legal   = csr_implemented(wr_addr) && (wr_addr[11:10] != 2'b11);
      wr_illegal = wr_en && !wr_legal;
      wr_fire    = wr_en && wr_legal && (wr_op_e'(wr_op) != WR_NOP);
      wr_raw     = csr_rmw(wr_op_e'(wr_op), csr_read(wr_addr), wr_src);
      wr_val     = wr_raw;
      case (wr_addr)
         CSR_MSTATUS: wr_val = mstatus_word(wr_raw[MSTATUS_MIE], wr_raw[MSTATUS_MPIE]);
         CSR_MTVEC, CSR_MEPC: wr_val = wr_raw & ~32'h3;
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
            wr_val = HAS_COUNTERS ? wr_raw : '0;
         default: wr_val = wr_raw;
      endcase
      // Trap and MRET own the CSRs they update; a software write to those is dropped.
      wr_blocked = ((wr_addr == CSR_MSTATUS) && (trap_valid || mret_valid)) ||
                   (((wr_addr == CSR_MEPC) || (wr_addr == CSR_MCAUSE)) && trap_valid);
      wr_commit  = wr_fire && !wr_blocked;
   end

   always_comb begin
      rd_illegal = !csr_implemented(rd_addr);
      if (RD_BYPASS && wr_commit && (wr_addr == rd_addr)) begin
         rd_data = wr_val;
      end else begin
         rd_data = csr_read(rd_addr);
      end
   end

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mscratch_d = mscratch_q;
      if (trap_valid) begin
         mepc_d   = trap_pc & ~32'h3;
         mcause_d = trap_cause;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_valid) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end
      if (wr_commit) begin
         case (wr_addr)
            CSR_MSTATUS: begin
               mie_d  = wr_val[MSTATUS_MIE];
               mpie_d = wr_val[MSTATUS_MPIE];
            end
            CSR_MTVEC:    mtvec_d    = wr_val;
            CSR_MSCRATCH: mscratch_d = wr_val;
            CSR_MEPC:     mepc_d     = wr_val;
            CSR_MCAUSE:   mcause_d   = wr_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie_q      <= MSTATUS_RST[MSTATUS_MIE];
         mpie_q     <= MSTATUS_RST[MSTATUS_MPIE];
         mtvec_q    <= MTVEC_RST & ~32'h3;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mscratch_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mscratch_q <= mscratch_d;
      end
   end

   if (HAS_COUNTERS) begin : g_counters
      csr_counter64 u_mcycle (
         .clk     (clk),
         .rst     (rst),
         .inc_i   (1'b1),
         .wr_lo_i (wr_commit && (wr_addr == CSR_MCYCLE)),
         .wr_hi_i (wr_commit && (wr_addr == CSR_MCYCLEH)),
         .wdata_i (wr_val),
         .value_o (mcycle)
      );
      csr_counter64 u_minstret (
         .clk     (clk),
         .rst     (rst),
         .inc_i   (retire),
         .wr_lo_i (wr_commit && (wr_addr == CSR_MINSTRET)),
         .wr_hi_i (wr_commit && (wr_addr == CSR_MINSTRETH)),
         .wdata_i (wr_val),
         .value_o (minstret)
      );
   end else begin : g_no_counters
      assign mcycle   = '0;
      assign minstret = '0;
   end

   assign trap_vec = mtvec_q;
   assign epc      = mepc_q;
   assign mie      = mie_q;

endmodule
